// File: rtl/mem_access_arbiter_pkg.sv
// Shared constants and helpers for the scratch-memory arbiter.
package mem_access_arbiter_pkg;

    localparam int NREQ         = 3;
    localparam int AW           = 4;
    localparam int DW           = 8;
    localparam int MAX_LOCK_DEF = 4;

    localparam int REQ_CTRL = 0;
    localparam int REQ_COMP = 1;
    localparam int REQ_DISP = 2;

    typedef enum logic {
        LK_IDLE  = 1'b0,
        LK_BURST = 1'b1
    } lock_state_e;

    function automatic logic [1:0] oh_to_idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

    function automatic logic [1:0] inc_mod3(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Requester-side bus of the scratch-memory arbiter (packed per-requester fields).
interface mem_access_arbiter_if
    import mem_access_arbiter_pkg::*;
    ();

    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    wr;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;

    modport master (
        output req, lock, wr, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, wr, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_access_arbiter_pick.sv
// Combinational 3-way rotating priority encoder; ptr names the highest-priority input.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt,
    output logic       valid
);

    always_comb begin
        gnt = 3'b000;
        case (ptr)
            2'd1: begin
                if      (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            2'd2: begin
                if      (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

    assign valid = |req;

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing the single-port 16x8 scratch memory among three requesters.
//   state    | meaning
//   LK_IDLE  | no burst; winner chosen round-robin from rr_ptr
//   LK_BURST | owner keeps the port while it holds req and lock, up to MAX_LOCK grants
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
    #(parameter int unsigned MAX_LOCK = MAX_LOCK_DEF)
    (
    input  logic                 clk,
    input  logic                 rst,
    mem_access_arbiter_if.slave  bus,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_wr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 busy
);

    lock_state_e     lock_state_q, lock_state_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [1:0]      owner_q, owner_d;
    logic [3:0]      lock_cnt_q, lock_cnt_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;

    logic [NREQ-1:0] pick_gnt;
    logic            pick_valid;
    logic [NREQ-1:0] win_oh;
    logic [1:0]      win_idx;
    logic            lock_cont;
    logic [3:0]      cnt_inc;

    rr_pick3 u_pick (
        .req   (bus.req),
        .ptr   (rr_ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        lock_state_d = lock_state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        lock_cnt_d   = lock_cnt_q;
        cnt_inc      = lock_cnt_q + 4'd1;

        // A burst only continues while the owner still asks with lock held.
        lock_cont = (lock_state_q == LK_BURST) && bus.req[owner_q] && bus.lock[owner_q];
        win_oh    = lock_cont ? (3'b001 << owner_q) : pick_gnt;
        if (rst || !pick_valid) win_oh = '0;
        win_idx   = oh_to_idx(win_oh);

        mem_addr  = rst ? '0 : bus.addr[win_idx*AW +: AW];
        mem_wdata = rst ? '0 : bus.wdata[win_idx*DW +: DW];
        mem_wr    = bus.wr[win_idx] & win_oh[win_idx];
        rvalid_d  = win_oh & ~bus.wr;

        if (|win_oh) begin
            if (lock_cont) begin
                if (cnt_inc == 4'(MAX_LOCK)) begin
                    lock_state_d = LK_IDLE;
                    lock_cnt_d   = 4'd0;
                    rr_ptr_d     = inc_mod3(owner_q);
                end else begin
                    lock_cnt_d   = cnt_inc;
                end
            end else begin
                rr_ptr_d = inc_mod3(win_idx);
                if (bus.lock[win_idx] && (MAX_LOCK > 1)) begin
                    lock_state_d = LK_BURST;
                    owner_d      = win_idx;
                    lock_cnt_d   = 4'd1;
                end else begin
                    lock_state_d = LK_IDLE;
                    lock_cnt_d   = 4'd0;
                end
            end
        end else begin
            lock_state_d = LK_IDLE;
            lock_cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state_q <= LK_IDLE;
            rr_ptr_q     <= 2'd0;
            owner_q      <= 2'd0;
            lock_cnt_q   <= 4'd0;
            rvalid_q     <= '0;
        end else begin
            lock_state_q <= lock_state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rvalid_q     <= rvalid_d;
        end
    end

    // Gating with rst kills a read already in flight when reset arrives.
    assign bus.gnt    = win_oh;
    assign bus.rvalid = rvalid_q & {NREQ{~rst}};
    assign bus.rdata  = mem_rdata;
    assign busy       = (lock_cnt_q != 4'd0) && !rst;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural 16x8 one-cycle-latency memory.
module tb_mem_access_arbiter;
    import mem_access_arbiter_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [7:0]    mem [16];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_arbiter_if bus ();

    mem_access_arbiter #(.MAX_LOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Memory contents start at 0x10+address whenever reset is high.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w);
        @(negedge clk);
        bus.req  = r;
        bus.lock = l;
        bus.wr   = w;
        #1;
    endtask

    task automatic set_port(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.addr[i*AW +: AW]  = a;
        bus.wdata[i*DW +: DW] = d;
    endtask

    logic [2:0] exp_rot  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] exp_lk_g [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
    logic       exp_lk_b [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [2:0] prev;
        rst = 1'b1;
        bus.req = '0; bus.lock = '0; bus.wr = '0; bus.addr = '0; bus.wdata = '0;

        // Reset holds every output low even with all requesters asking to write.
        go(3'b111, 3'b000, 3'b111);
        set_port(0, 4'h7, 8'hC3);
        set_port(1, 4'h9, 8'h3C);
        #1;
        chk("rst_gnt", bus.gnt, 3'b000);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_addr", mem_addr, 4'h0);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rvalid", bus.rvalid, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0; bus.req = '0; bus.wr = '0;

        for (int i = 0; i < 5; i++) begin
            go(3'b000, 3'b000, 3'b000);
            chk("idle_gnt", bus.gnt, 3'b000);
            chk("idle_rvalid", bus.rvalid, 3'b000);
            chk("idle_mem_wr", mem_wr, 1'b0);
            chk("idle_busy", busy, 1'b0);
        end

        // R0 writes 0x5A to addr 3, R1 reads it back.
        set_port(0, 4'h3, 8'h5A);
        set_port(1, 4'h3, 8'h00);
        go(3'b001, 3'b000, 3'b001);
        chk("wr_gnt", bus.gnt, 3'b001);
        chk("wr_mem_wr", mem_wr, 1'b1);
        chk("wr_mem_addr", mem_addr, 4'h3);
        chk("wr_mem_wdata", mem_wdata, 8'h5A);
        go(3'b010, 3'b000, 3'b000);
        chk("rd_gnt", bus.gnt, 3'b010);
        chk("rd_mem_wr", mem_wr, 1'b0);
        chk("rd_rvalid_early", bus.rvalid, 3'b000);
        go(3'b000, 3'b000, 3'b000);
        chk("rd_rvalid", bus.rvalid, 3'b010);
        chk("rd_rdata", bus.rdata, 8'h5A);
        chk("nogrant_addr_r0", mem_addr, 4'h3);

        // Read before a write sees the old value, read after sees the new one.
        go(3'b010, 3'b000, 3'b000);
        chk("rbw_gnt1", bus.gnt, 3'b010);
        set_port(0, 4'h3, 8'hA5);
        go(3'b001, 3'b000, 3'b001);
        chk("rbw_gnt0", bus.gnt, 3'b001);
        chk("rbw_rvalid1", bus.rvalid, 3'b010);
        chk("rbw_old", bus.rdata, 8'h5A);
        set_port(2, 4'h3, 8'h00);
        go(3'b100, 3'b000, 3'b000);
        chk("raw_gnt2", bus.gnt, 3'b100);
        chk("raw_rvalid_none", bus.rvalid, 3'b000);
        go(3'b000, 3'b000, 3'b000);
        chk("raw_rvalid2", bus.rvalid, 3'b100);
        chk("raw_new", bus.rdata, 8'hA5);

        // Three-way rotation of reads; rr_ptr is 0 here.
        set_port(0, 4'h4, 8'h00);
        set_port(1, 4'h5, 8'h00);
        set_port(2, 4'h6, 8'h00);
        prev = 3'b000;
        for (int i = 0; i < 6; i++) begin
            go(3'b111, 3'b000, 3'b000);
            chk("rot_gnt", bus.gnt, exp_rot[i]);
            chk("rot_rvalid", bus.rvalid, prev);
            if (i > 0) chk("rot_rdata", bus.rdata, 8'h14 + 8'((i - 1) % 3));
            prev = exp_rot[i];
        end
        go(3'b000, 3'b000, 3'b000);
        chk("rot_rvalid_last", bus.rvalid, 3'b100);
        chk("rot_rdata_last", bus.rdata, 8'h16);

        // One R0 grant moves rr_ptr to 1, then R1 locks against R0 and R2.
        go(3'b001, 3'b000, 3'b000);
        chk("pre_lock_gnt", bus.gnt, 3'b001);
        for (int i = 0; i < 6; i++) begin
            go(3'b111, 3'b010, 3'b000);
            chk("lock_gnt", bus.gnt, exp_lk_g[i]);
            chk("lock_busy", busy, exp_lk_b[i]);
        end

        // R1 burst broken after two grants; rr_ptr is 1 on entry.
        go(3'b111, 3'b010, 3'b000);
        chk("drop_gnt1", bus.gnt, 3'b010);
        chk("drop_busy1", busy, 1'b0);
        go(3'b111, 3'b010, 3'b000);
        chk("drop_gnt2", bus.gnt, 3'b010);
        chk("drop_busy2", busy, 1'b1);
        go(3'b111, 3'b000, 3'b000);
        chk("drop_rr_gnt", bus.gnt, 3'b100);
        chk("drop_busy3", busy, 1'b1);
        go(3'b111, 3'b000, 3'b000);
        chk("drop_next_gnt", bus.gnt, 3'b001);
        chk("drop_busy4", busy, 1'b0);

        // Reset in the cycle after a granted read suppresses its rvalid.
        go(3'b100, 3'b000, 3'b000);
        chk("rstrd_gnt", bus.gnt, 3'b100);
        @(negedge clk);
        rst = 1'b1; bus.req = 3'b000;
        #1;
        chk("rstrd_rvalid", bus.rvalid, 3'b000);
        chk("rstrd_gnt_off", bus.gnt, 3'b000);
        @(negedge clk);
        rst = 1'b0; bus.req = 3'b111; bus.lock = 3'b000; bus.wr = 3'b000;
        #1;
        chk("post_rst_rvalid", bus.rvalid, 3'b000);
        chk("post_rst_gnt", bus.gnt, 3'b001);
        go(3'b000, 3'b000, 3'b000);
        chk("post_rst_rvalid0", bus.rvalid, 3'b001);
        chk("post_rst_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
